z80_ex_sp_seq: RTL
==================

Name: z80_ex_sp_seq

Overview:
- Sequential multi-cycle executor for the EX (SP),rr family: EX (SP),HL (E3), EX (SP),IX (DD E3) and EX (SP),IY (FD E3).
- Runs the Z80 bus order: read low, read high, write high, write low. Drives a req/ack memory port and returns the exchanged register pair.
- Sits between the core's instruction sequencer and the memory bus arbiter.
- Gives the z80fi instruction spec checkers a cycle-accurate reference for the 2-read/2-write exchange.

Parameters:
- ADDR_W, 16, width of SP and memory address; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, bus data width; the register pair is 2*DATA_W wide.
- IDX_EN, 1, when 0 the IX/IY selects are illegal (err), and only HL is supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin an exchange; sampled only in IDLE
- sel  input  2  00=HL, 01=IX, 10=IY, 11=illegal
- sp_in  input  ADDR_W  stack pointer, captured at start
- rr_in  input  2*DATA_W  selected pair value, captured at start ([high byte : low byte])
- busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive
- done  output  1  one-cycle pulse when the operation completes
- err  output  1  one-cycle pulse, coincident with done, for an illegal sel
- rr_out  output  2*DATA_W  new pair value; valid when done is high and held until the next done
- mem_req  output  1  bus request
- mem_we  output  1  1=write, 0=read; valid while mem_req is high
- mem_addr  output  ADDR_W  access address
- mem_wdata  output  DATA_W  write data
- mem_rdata  input  DATA_W  read data, valid in the mem_ack cycle of a read
- mem_ack  input  1  access completes in any cycle where mem_req and mem_ack are both high

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. busy, done, err, mem_req and mem_we are 0. mem_addr, mem_wdata and rr_out are 0.
- States: IDLE, RD_LO, RD_HI, WR_HI, WR_LO, FIN.
- IDLE:
  - On start with a legal sel: capture sp_in into sp_q and rr_in into rr_q, then go to RD_LO.
  - On start with sel=11, or with sel!=00 and IDX_EN=0: go to FIN with error flag set. No bus access occurs.
  - start is ignored in every other state.
- RD_LO: mem_req=1, mem_we=0, mem_addr=sp_q. On ack, latch mem_rdata into lo_q and go to RD_HI.
- RD_HI: read at address sp_q+1 (wraps, e.g. sp_q=FFFF gives 0000). On ack, latch mem_rdata into hi_q and go to WR_HI.
- WR_HI: write at sp_q+1 with mem_wdata=rr_q high byte. On ack, go to WR_LO.
- WR_LO: write at sp_q with mem_wdata=rr_q low byte. On ack, go to FIN.
- FIN:
  - Assert done for one cycle, with err=error flag.
  - rr_out={hi_q,lo_q} on success; rr_out is unchanged on error.
  - Next state is IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are stable and unchanged while waiting for ack.
  - mem_req drops in the cycle after the ack of WR_LO.
  - Within an instruction, mem_req stays high across back-to-back accesses when ack arrives each cycle.
- Latency with mem_ack tied high: start at cycle 0; accesses in cycles 1-4; done in cycle 5. Each wait cycle on an access adds 1 cycle.
- mem_rdata is sampled only in ack cycles of read states. Ack seen in IDLE or FIN is ignored.
- Reset asserted mid-operation aborts immediately:
  - No further bus access.
  - No done.
  - Memory may be partially written; this is acceptable.
- sel has no effect on the bus sequence. It only gates legality and is reported for tracing.

Test Plan:
- HL exchange, ack tied high: sp_in=1234, rr_in=ABCD, mem[1234]=11, mem[1235]=22.
  - Accesses are R@1234, R@1235, W@1235=AB, W@1234=CD on cycles 1-4.
  - done at cycle 5 with rr_out=2211 and err=0.
- SP wrap: sp_in=FFFF, sel=01, mem[FFFF]=5A, mem[0000]=A5, rr_in=0102.
  - Accesses are R@FFFF, R@0000, W@0000=01, W@FFFF=02.
  - rr_out=A55A.
- Wait states: insert 2 idle ack cycles before each access.
  - Address and data are stable while waiting.
  - done at cycle 13; mem contents and rr_out are as in the first scenario.
- Illegal: sel=11 gives no mem_req, done=1 and err=1 at cycle 1, with rr_out unchanged.
  - With IDX_EN=0, sel=10 behaves the same way.
- Start while busy: a second start pulse on cycle 2 is ignored.
  - Exactly 4 accesses occur and there is a single done pulse.
- Reset mid-op: deassert reset_n during WR_HI.
  - All outputs are immediately 0 and the state is IDLE.
  - A new start after reset is released completes normally.

Source files
------------

// File: rtl/z80_ex_sp_seq.sv
// -----------------------------------------------------------------------------
// z80_ex_sp_seq
//
// Multi-cycle executor for EX (SP),HL / EX (SP),IX / EX (SP),IY.
// The exchange runs in Z80 bus order:
//   read [SP], read [SP+1], write [SP+1] = rr.hi, write [SP] = rr.lo
// It then returns the pair read from the stack as rr_out = {[SP+1],[SP]}.
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   start             one-cycle request, only looked at while idle
//   sel               00=HL, 01=IX, 10=IY, 11=illegal (IX/IY illegal if !IDX_EN)
//   sp_in, rr_in      stack pointer and selected pair, captured on start
//   busy              high from the cycle after an accepted start up to and
//                     including the done cycle
//   done, err         one-cycle completion pulse; err marks an illegal sel
//   rr_out            exchanged pair, updated on successful completion only
//   mem_*             registered request/acknowledge memory port
//   dbg_state         current FSM state (IDLE=0, RD_LO=1, RD_HI=2, WR_HI=3,
//                     WR_LO=4, FIN=5) for trace and checker binding
//
// Memory handshake: mem_req, mem_we, mem_addr and mem_wdata are registered and
// held constant until an access completes. An access completes in every cycle
// where mem_req and mem_ack are both high. mem_rdata is consumed only in that
// cycle and only for reads. mem_ack in cycles without mem_req has no effect.
// -----------------------------------------------------------------------------
module z80_ex_sp_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int IDX_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            sel,
  input  logic [ADDR_W-1:0]     sp_in,
  input  logic [2*DATA_W-1:0]   rr_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2*DATA_W-1:0]   rr_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_HI = 3'd3,
    S_WR_LO = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sp_q;
  logic [2*DATA_W-1:0] rr_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   hi_q;

  logic                sel_legal;
  logic                acc_done;
  logic [ADDR_W-1:0]   sp_inc;

  // HL is always legal; the index pairs need IDX_EN, and 11 never decodes.
  assign sel_legal = (sel == 2'b00) || ((IDX_EN != 0) && (sel != 2'b11));
  assign acc_done  = mem_req && mem_ack;
  // Wraps modulo 2^ADDR_W, so SP=FFFF addresses 0000 for the high byte.
  assign sp_inc    = sp_q + ADDR_W'(1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rr_out    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sp_q      <= '0;
      rr_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (sel_legal) begin
              sp_q     <= sp_in;
              rr_q     <= rr_in;
              // First access is presented in the very next cycle.
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= sp_in;
              state    <= S_RD_LO;
            end else begin
              // Illegal select: complete at once without touching the bus.
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_FIN;
            end
          end
        end

        S_RD_LO: begin
          if (acc_done) begin
            lo_q     <= mem_rdata;
            mem_addr <= sp_inc;
            state    <= S_RD_HI;
          end
        end

        S_RD_HI: begin
          if (acc_done) begin
            hi_q      <= mem_rdata;
            mem_we    <= 1'b1;
            mem_wdata <= rr_q[2*DATA_W-1:DATA_W];
            state     <= S_WR_HI;
          end
        end

        S_WR_HI: begin
          if (acc_done) begin
            mem_wdata <= rr_q[DATA_W-1:0];
            mem_addr  <= sp_q;
            state     <= S_WR_LO;
          end
        end

        S_WR_LO: begin
          if (acc_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            rr_out  <= {hi_q, lo_q};
            state   <= S_FIN;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
